// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MIPS multiply/divide unit with HI/LO registers.
// Define MULDIV_DIV_EN to compile in the divider datapath (DIV/DIVU).
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] { IDLE, CALC, FIX } state_t;
   state_t state, state_nx;

   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, acc_step, res;
   logic [WIDTH-1:0]   bmag, a_mag, b_mag;
   logic [WIDTH:0]     sum;
   logic               a_sgn, b_sgn, neg_q, accept;
`ifdef MULDIV_DIV_EN
   logic               is_div, a_neg_q, qbit;
   logic [WIDTH-1:0]   a_orig, rem_nx;
   logic [WIDTH:0]     r_sh;
`endif

   // Only MULT (00) and DIV (10) are signed: op[0] clear
   assign a_sgn = ~op[0] & src_a[WIDTH-1];
   assign b_sgn = ~op[0] & src_b[WIDTH-1];
   assign a_mag = a_sgn ? -src_a : src_a;
   assign b_mag = b_sgn ? -src_b : src_b;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
`ifdef MULDIV_DIV_EN
            accept = start;
`else
            accept = start & ~op[1];
`endif
            if (accept) state_nx = CALC;
         end
         CALC: if (cnt == LAST) state_nx = FIX;
         FIX: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         done  <= (state == FIX);
      end
   end

   // One iteration: shift-add multiply, or restoring divide step
   always_comb begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : '0);
      acc_step = {sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      r_sh   = acc[2*WIDTH-1:WIDTH-1];
      qbit   = (r_sh >= {1'b0, bmag});
      rem_nx = qbit ? WIDTH'(r_sh - {1'b0, bmag}) : r_sh[WIDTH-1:0];
      if (is_div) acc_step = {rem_nx, acc[WIDTH-2:0], qbit};
`endif
   end

   always_comb begin
      res = neg_q ? -acc : acc;
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         if (bmag == '0) begin
            res = {a_orig, {WIDTH{1'b1}}};
         end else begin
            res[WIDTH-1:0] = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res[2*WIDTH-1:WIDTH] = a_neg_q ? -acc[2*WIDTH-1:WIDTH]
                                           : acc[2*WIDTH-1:WIDTH];
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         acc   <= '0;
         bmag  <= '0;
         neg_q <= 1'b0;
         hi    <= '0;
         lo    <= '0;
`ifdef MULDIV_DIV_EN
         is_div  <= 1'b0;
         a_neg_q <= 1'b0;
         a_orig  <= '0;
`endif
      end else begin
         if (state == IDLE && hi_we) hi <= wdata;
         if (state == IDLE && lo_we) lo <= wdata;
         if (accept) begin
            cnt   <= '0;
            acc   <= {{WIDTH{1'b0}}, a_mag};
            bmag  <= b_mag;
            neg_q <= a_sgn ^ b_sgn;
`ifdef MULDIV_DIV_EN
            is_div  <= op[1];
            a_neg_q <= a_sgn;
            a_orig  <= src_a;
`endif
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            acc <= acc_step;
         end else if (state == FIX) begin
            hi <= res[2*WIDTH-1:WIDTH];
            lo <= res[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Divide vectors run only when MULDIV_DIV_EN is defined.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;
   int lat, nbusy, seen;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch, follow busy until done (bounded), then check result
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      step();
      start = 1'b0;
      chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_e0"}, {31'd0, done}, 32'd0);
      nbusy = 0;
      lat   = 0;
      while (!done && lat < 40) begin
         if (busy) nbusy++;
         step();
         lat++;
      end
      chk({tag, "_lat"}, lat, 33);
      chk({tag, "_busycyc"}, nbusy, 33);
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hi"}, hi, ehi);
      chk({tag, "_lo"}, lo, elo);
   endtask

   initial begin
      repeat (2) step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      rst = 1'b0;
      step();

      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'h0000CAFE;
      step();
      hi_we = 1'b0;
      lo_we = 1'b0;
      chk("mt_hi", hi, 32'h0000CAFE);
      chk("mt_lo", lo, 32'h0000CAFE);

`ifndef MULDIV_DIV_EN
      start = 1'b1;
      op    = 2'b10;
      src_a = 32'd9;
      src_b = 32'd3;
      step();
      start = 1'b0;
      chk("nodiv_busy", {31'd0, busy}, 32'd0);
      seen = 0;
      repeat (40) begin
         step();
         if (done || busy) seen++;
      end
      chk("nodiv_act", seen, 0);
      chk("nodiv_hi", hi, 32'h0000CAFE);
      chk("nodiv_lo", lo, 32'h0000CAFE);
`endif

      // Start and MTHI while busy must be ignored
      start = 1'b1;
      op    = 2'b01;
      src_a = 32'd6;
      src_b = 32'd7;
      step();
      start = 1'b0;
      repeat (4) step();
      start = 1'b1;
      src_a = 32'd9;
      src_b = 32'd9;
      hi_we = 1'b1;
      wdata = 32'h0000DEAD;
      step();
      start = 1'b0;
      hi_we = 1'b0;
      chk("busy_mthi", hi, 32'h0000CAFE);
      lat = 5;
      while (!done && lat < 40) begin
         step();
         lat++;
      end
      chk("busy_lat", lat, 33);
      chk("busy_hi", hi, 32'd0);
      chk("busy_lo", lo, 32'd42);
      step();
      chk("busy_noq", {31'd0, busy}, 32'd0);
      chk("busy_pulse", {31'd0, done}, 32'd0);

      // Consecutive run_op calls launch in the done cycle (back-to-back)
      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5,
             32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("mult_nn", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD,
             32'h00000000, 32'h00000006);
`ifdef MULDIV_DIV_EN
      run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2,
             32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
      run_op("div_zero", 2'b10, 32'h12345678, 32'd0,
             32'h12345678, 32'hFFFFFFFF);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
             32'h00000000, 32'h80000000);
      run_op("divu_big", 2'b11, 32'hFFFFFFFF, 32'h00010000,
             32'h0000FFFF, 32'h0000FFFF);
`endif
      step();

      // Reset in the middle of an operation
      start = 1'b1;
      op    = 2'b01;
      src_a = 32'd5;
      src_b = 32'd5;
      step();
      start = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      chk("mrst_hi", hi, 32'd0);
      chk("mrst_lo", lo, 32'd0);
      seen = 0;
      repeat (40) begin
         step();
         if (done) seen++;
      end
      chk("mrst_nodone", seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
